// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, LSB-first serial-out stage with a one-word holding buffer
// so back-to-back words stream without a bubble between them.
module piso_serializer #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [width-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             word_last,
    output logic             busy
);
    localparam int CW = $clog2(width);
    localparam logic [CW-1:0] CNT_MAX = CW'(width - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [width-1:0] sreg_q, sreg_d;
    logic [width-1:0] pbuf_q, pbuf_d;
    logic             pvalid_q, pvalid_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic             last_bit;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            pbuf_q   <= '0;
            pvalid_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            pbuf_q   <= pbuf_d;
            pvalid_q <= pvalid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign accept   = din_valid && !pvalid_q;
    assign last_bit = cnt_q == CNT_MAX;

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        pbuf_d   = pbuf_q;
        pvalid_d = pvalid_q;
        cnt_d    = cnt_q;
        if (state_q == IDLE) begin
            if (accept) begin
                sreg_d  = din;
                cnt_d   = '0;
                state_d = SHIFT;
            end
        end else if (!last_bit) begin
            sreg_d = sreg_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            if (accept) begin
                pbuf_d   = din;
                pvalid_d = 1'b1;
            end
        end else begin
            // Last bit: reload from the buffer first, else take a fresh word, else go idle.
            cnt_d = '0;
            if (pvalid_q) begin
                sreg_d   = pbuf_q;
                pvalid_d = 1'b0;
            end else if (accept) begin
                sreg_d = din;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        din_ready = !pvalid_q;
        s_valid   = state_q == SHIFT;
        s_out     = s_valid ? sreg_q[0] : 1'b0;
        word_last = s_valid && last_bit;
        busy      = s_valid || pvalid_q;
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench; expected bits and words are queued at acceptance
// and compared against the serial stream and a downstream right-shift register.
module tb_piso_serializer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready, s_out, s_valid, word_last, busy;

    logic [W-1:0] shreg = '0;
    logic [1:0]   bq[$];
    logic [W-1:0] wq[$];
    logic         chk_w = 1'b0;
    int           checks = 0;
    int           errors = 0;

    piso_serializer #(.width(W)) dut (
        .clk(clk), .clr_n(clr_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .s_out(s_out), .s_valid(s_valid), .word_last(word_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Consumer model: right-shift register fed by s_out.
    always @(posedge clk) if (s_valid) shreg <= {s_out, shreg[W-1:1]};

    // Inputs are stable from posedge+1 to the next posedge, so a handshake seen here
    // is the one taken at the coming edge; its bits are queued after this cycle's pop.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!clr_n) begin
            bq.delete();
            wq.delete();
            chk_w = 1'b0;
        end else begin
            if (chk_w) begin
                chk_w = 1'b0;
                if (wq.size() == 0) check("word_q", 8'd0, 8'd1);
                else check("word", 8'(shreg), 8'(wq.pop_front()));
            end
            if (s_valid) begin
                if (bq.size() == 0) check("extra_bit", 8'd1, 8'd0);
                else begin
                    e = bq.pop_front();
                    check("s_out", 8'(s_out), 8'(e[0]));
                    check("word_last", 8'(word_last), 8'(e[1]));
                    if (word_last) chk_w = 1'b1;
                end
            end else begin
                if (bq.size() != 0) check("gap", 8'd0, 8'd1);
                check("idle_out", {6'd0, s_out, word_last}, 8'd0);
            end
            if (din_valid && din_ready) begin
                for (int i = 0; i < W; i++) bq.push_back({i == W - 1, din[i]});
                wq.push_back(din);
            end
        end
    end

    // Presents w and returns at posedge+1 of the edge that accepted it.
    task automatic send(input logic [W-1:0] w);
        logic r;
        bit done = 0;
        din = w;
        din_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk) r = din_ready;
            @(posedge clk);
            done = r;
        end
        #1;
        din_valid = 1'b0;
        if (!done) check("send_timeout", 8'd0, 8'd1);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset and idle
        cyc(3);
        check("rst_s_valid", 8'(s_valid), 8'd0);
        check("rst_s_out", 8'(s_out), 8'd0);
        check("rst_last", 8'(word_last), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_ready", 8'(din_ready), 8'd1);
        #3 clr_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("idle", {4'd0, s_valid, s_out, busy, din_ready}, 8'h01);
        end
        // Single word, latency and consumer result
        send(4'b1011);
        check("lat_valid", 8'(s_valid), 8'd1);
        check("lat_bit0", 8'(s_out), 8'd1);
        cyc(3);
        check("w1_last", 8'(word_last), 8'd1);
        cyc(1);
        check("w1_done", 8'(s_valid), 8'd0);
        cyc(3);
        // Back-to-back with buffering; din_ready profile over cycles 1..5
        send(4'h5);
        check("rdy_c1", 8'(din_ready), 8'd1);
        send(4'hC);
        check("rdy_c2", 8'(din_ready), 8'd0);
        cyc(1);
        check("rdy_c3", 8'(din_ready), 8'd0);
        check("busy_c3", 8'(busy), 8'd1);
        cyc(1);
        check("rdy_c4", 8'(din_ready), 8'd0);
        check("last_c4", 8'(word_last), 8'd1);
        cyc(1);
        check("rdy_c5", 8'(din_ready), 8'd1);
        check("cont_c5", 8'(s_valid), 8'd1);
        cyc(8);
        // New word arriving exactly in the last-bit cycle
        send(4'hA);
        cyc(3);
        check("a_last", 8'(word_last), 8'd1);
        send(4'h3);
        check("no_bubble", 8'(s_valid), 8'd1);
        check("b3_bit0", 8'(s_out), 8'd1);
        cyc(8);
        // Asynchronous reset mid-word with a buffered word
        send(4'hF);
        send(4'h6);
        @(posedge clk);
        #3 clr_n = 1'b0;
        #1;
        check("ar_valid", 8'(s_valid), 8'd0);
        check("ar_busy", 8'(busy), 8'd0);
        check("ar_ready", 8'(din_ready), 8'd1);
        @(posedge clk);
        #5 clr_n = 1'b1;
        cyc(2);
        send(4'h9);
        cyc(8);
        // Held request while the buffer is full
        send(4'h2);
        send(4'h4);
        check("hold_rdy", 8'(din_ready), 8'd0);
        send(4'h7);
        cyc(16);
        check("drain_bits", 8'(bq.size()), 8'd0);
        check("drain_words", 8'(wq.size()), 8'd0);
        check("end_busy", 8'(busy), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out stage directly upstream of the FFT's serial-in right-shift deserializer.
- Accepts parallel words over a valid/ready handshake, buffers one word, and emits them LSB-first on a 1-bit serial line.
- LSB-first order means that after width shift clocks the downstream right-shift register holds the word with the original bit order.
- Sustains gapless back-to-back words and flags the last bit of each word so the consumer knows when its parallel output is complete.

Parameters:
- width, 4, word width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous, active-low reset.
- din  input  width  parallel word to serialize.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept a word this cycle.
- s_out  output  1  serial data bit, LSB of each word first; drives the deserializer's s_in.
- s_valid  output  1  s_out carries a valid bit this cycle.
- word_last  output  1  high during the cycle s_out carries bit width-1 of a word.
- busy  output  1  high when the shift register or the holding buffer holds data.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on clr_n. All state updates on rising clk except reset.
- Internal state:
  - sreg[width-1:0]: shift register.
  - cnt: bit counter, 0..width-1, $clog2(width) bits.
  - pbuf[width-1:0] with flag pvalid: one-word holding buffer.
  - FSM states IDLE and SHIFT.
- Reset (clr_n low, takes effect immediately, asynchronously):
  - state=IDLE, cnt=0, sreg=0, pbuf=0, pvalid=0.
  - Outputs: s_out=0, s_valid=0, word_last=0, busy=0, din_ready=1.
- Output definitions:
  - din_ready = !pvalid.
  - accept = din_valid && din_ready.
  - s_valid = (state==SHIFT).
  - s_out = s_valid ? sreg[0] : 0.
  - word_last = s_valid && (cnt==width-1).
  - busy = s_valid || pvalid.
- IDLE:
  - On accept: sreg<=din, cnt<=0, go to SHIFT.
  - Latency: a word accepted at edge k puts bit 0 on s_out in the cycle after edge k.
- SHIFT, cnt < width-1:
  - Each edge: sreg<=sreg>>1, cnt<=cnt+1.
  - On accept: pbuf<=din, pvalid<=1.
- SHIFT, cnt == width-1 (the last-bit cycle):
  - If pvalid: sreg<=pbuf, pvalid<=0, cnt<=0, stay in SHIFT. No accept can occur this cycle because din_ready=0.
  - Else if accept: sreg<=din, cnt<=0, stay in SHIFT. There is no bubble.
  - Else: go to IDLE, cnt<=0.
- Throughput: one word per width cycles sustained. s_valid stays high continuously while words keep arriving.
- din must be held stable while din_valid=1 and din_ready=0. The block never drops or duplicates a word.
- Downstream timing: the consumer's parallel output holds the complete word starting the cycle after word_last is high.
- Reset mid-word discards both the in-flight word and the buffered word. After release, operation resumes from IDLE.

Test Plan:
1. Hold clr_n=0 for 3 cycles -> s_valid=0, s_out=0, word_last=0, busy=0, din_ready=1. Release with din_valid=0 for 5 cycles -> outputs unchanged.
2. Accept din=4'b1011 at edge 0 -> s_out=1,1,0,1 in cycles 1-4; s_valid high in cycles 1-4 only; word_last high in cycle 4 only. A chained width-4 right-shift stage then holds 4'b1011.
3. din_valid held high with 4'h5 then 4'hC (din switches after the first accept) -> 8 contiguous s_valid cycles with s_out=1,0,1,0,0,0,1,1. word_last is high in cycles 4 and 8. din_ready is low from the cycle after 4'hC is buffered until the cycle after the edge that ends cycle 4.
4. Pbuf empty; a new word 4'h3 presented only in the last-bit cycle of word 4'hA -> 4'h3's bit 0 appears in the next cycle, with no s_valid gap.
5. clr_n pulsed low asynchronously mid-cycle after 2 bits of 4'hF, with 4'h6 buffered -> s_valid and busy drop immediately. After release, accepting 4'h9 gives s_out=1,0,0,1 with no leftover bits from 4'hF or 4'h6.
6. din_valid high while din_ready=0 for 3 cycles with din held at 4'h7 -> 4'h7 is accepted exactly once when ready rises and is serialized exactly once.
